// File: rtl/z_axis_bcd.sv
// z_axis_bcd: sequential 16-bit binary to 5-digit BCD converter (double dabble).
// A conversion takes 16 shift cycles plus one DONE cycle. The digit and sign
// outputs are registered and only change when a conversion completes, so the
// display never sees partial results.
// Optional build macro: Z_AXIS_SIGNED_EN treats bin as two's complement and
// converts its magnitude, reporting the sign on z_axis_sign. When the macro is
// undefined, bin is unsigned and z_axis_sign stays 0.
module z_axis_bcd (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] bin,
  output logic        busy,
  output logic        done,
  output logic        z_axis_sign,
  output logic [3:0]  z_axis_ten_thousands,
  output logic [3:0]  z_axis_thousands,
  output logic [3:0]  z_axis_hundreds,
  output logic [3:0]  z_axis_tens,
  output logic [3:0]  z_axis_units
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CONVERT = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

  logic [1:0]  state;
  logic [4:0]  cnt;       // remaining shift iterations
  logic [35:0] sr;        // [35:16] five BCD nibbles, [15:0] binary operand
  logic        z_sign;    // sign captured at accept time
  logic [15:0] operand;   // value loaded into the binary part of sr
  logic        operand_neg;
  logic [35:0] sr_next;

`ifdef Z_AXIS_SIGNED_EN
  // Magnitude of a two's complement input; -32768 wraps to 16'h8000, which is
  // the correct unsigned magnitude 32768.
  assign operand_neg = bin[15];
  assign operand     = bin[15] ? (~bin + 16'd1) : bin;
`else
  assign operand_neg = 1'b0;
  assign operand     = bin;
`endif

  // One double-dabble step: correct every BCD nibble >= 5, then shift left.
  always_comb begin
    // NOTE: assign a default before any conditional update so no latch is inferred.
    sr_next = sr;
    for (int i = 0; i < 5; i++) begin
      if (sr_next[16+4*i +: 4] >= 4'd5) begin
        sr_next[16+4*i +: 4] = sr_next[16+4*i +: 4] + 4'd3;
      end
    end
    sr_next = {sr_next[34:0], 1'b0};
  end

  // Control FSM, shift register and registered outputs.
  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every register updates from pre-edge values.
    if (reset) begin
      state                <= S_IDLE;
      cnt                  <= 5'd0;
      sr                   <= 36'd0;
      z_sign               <= 1'b0;
      done                 <= 1'b0;
      z_axis_sign          <= 1'b0;
      z_axis_ten_thousands <= 4'd0;
      z_axis_thousands     <= 4'd0;
      z_axis_hundreds      <= 4'd0;
      z_axis_tens          <= 4'd0;
      z_axis_units         <= 4'd0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            sr     <= {20'd0, operand};
            cnt    <= 5'd16;
            z_sign <= operand_neg;
            state  <= S_CONVERT;
          end
        end
        S_CONVERT: begin
          sr  <= sr_next;
          cnt <= cnt - 5'd1;
          if (cnt == 5'd1) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          z_axis_ten_thousands <= sr[35:32];
          z_axis_thousands     <= sr[31:28];
          z_axis_hundreds      <= sr[27:24];
          z_axis_tens          <= sr[23:20];
          z_axis_units         <= sr[19:16];
          z_axis_sign          <= z_sign;
          done                 <= 1'b1;
          state                <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Busy covers both the shift phase and the output-update cycle.
  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_z_axis_bcd.sv
// tb_z_axis_bcd: self-checking bench for z_axis_bcd. A timeline model (accept
// edge, completion 17 edges later, digits from integer division) is compared
// with the DUT on every cycle; directed scenarios add literal expectations.
// Define Z_AXIS_SIGNED_EN for both files to check the signed build.
module tb_z_axis_bcd;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] bin;
  logic        busy, done, z_axis_sign;
  logic [3:0]  d4, d3, d2, d1, d0;
  logic [19:0] digits;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  z_axis_bcd dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .bin(bin),
    .busy(busy),
    .done(done),
    .z_axis_sign(z_axis_sign),
    .z_axis_ten_thousands(d4),
    .z_axis_thousands(d3),
    .z_axis_hundreds(d2),
    .z_axis_tens(d1),
    .z_axis_units(d0)
  );

  assign digits = {d4, d3, d2, d1, d0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference conversion: returns {sign, five BCD digits}.
  function automatic logic [20:0] model_conv(input logic [15:0] b);
    int mag;
    logic s;
    logic [19:0] r;
`ifdef Z_AXIS_SIGNED_EN
    s   = b[15];
    mag = b[15] ? (65536 - int'(b)) : int'(b);
`else
    s   = 1'b0;
    mag = int'(b);
`endif
    r[19:16] = 4'((mag / 10000) % 10);
    r[15:12] = 4'((mag / 1000) % 10);
    r[11:8]  = 4'((mag / 100) % 10);
    r[7:4]   = 4'((mag / 10) % 10);
    r[3:0]   = 4'(mag % 10);
    return {s, r};
  endfunction

  // Timeline model: accept at edge k when idle, results and done at edge k+17.
  int          edge_n = 0;
  bit          m_valid = 0;
  bit          m_active = 0;
  int          m_acc = 0;
  logic [19:0] m_pend_bcd, m_bcd;
  logic        m_pend_sign, m_sign, m_done;

  initial begin
    forever begin
      @(posedge clk);
      edge_n++;
      if (reset) begin
        m_active = 0;
        m_done   = 1'b0;
        m_bcd    = 20'd0;
        m_sign   = 1'b0;
        m_valid  = 1;
      end else begin
        m_done = 1'b0;
        if (m_active && edge_n == m_acc + 17) begin
          m_bcd    = m_pend_bcd;
          m_sign   = m_pend_sign;
          m_done   = 1'b1;
          m_active = 0;
        end else if (!m_active && start) begin
          m_active = 1;
          m_acc    = edge_n;
          {m_pend_sign, m_pend_bcd} = model_conv(bin);
        end
      end
    end
  end

  // Per-cycle compare of every output against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        check("cycle_outputs", {9'd0, busy, done, z_axis_sign, digits},
              {9'd0, logic'(m_active), m_done, m_sign, m_bcd});
      end
    end
  end

  // Pulse start for one edge, then count edges until done and busy cycles seen.
  task automatic run(input logic [15:0] b, output int offset, output int busy_cnt);
    int n;
    start = 1'b1;
    bin   = b;
    @(negedge clk);
    start    = 1'b0;
    bin      = 16'($urandom);
    n        = 1;
    busy_cnt = busy ? 1 : 0;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
      if (busy) busy_cnt++;
    end
    if (!done) check("done_timeout", 32'd0, 32'd1);
    offset = n - 1;
  endtask

  initial begin
    int off, bc, dcnt, idx, first, second;
    reset = 1'b1;
    start = 1'b0;
    bin   = 16'd0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {9'd0, busy, done, z_axis_sign, digits}, 32'd0);
    reset = 1'b0;

    // Zero operand: latency and busy length.
    run(16'd0, off, bc);
    check("zero_done_offset", off, 17);
    check("zero_busy_cycles", bc, 17);
    check("zero_digits", digits, 32'h00000);

    // Full-scale operand.
    run(16'hFFFF, off, bc);
`ifdef Z_AXIS_SIGNED_EN
    check("ffff_result", {z_axis_sign, digits}, {1'b1, 20'h00001});
`else
    check("ffff_result", {z_axis_sign, digits}, {1'b0, 20'h65535});
`endif

    // Start while busy is ignored; bin changes mid-flight have no effect.
    start = 1'b1;
    bin   = 16'd1234;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("busy_at_5th_cycle", busy, 1);
    start = 1'b1;
    bin   = 16'd9999;
    @(negedge clk);
    start = 1'b0;
    bin   = 16'($urandom);
    dcnt  = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check("ignored_start_done_count", dcnt, 1);
    check("ignored_start_digits", digits, 32'h01234);
    repeat (10) @(negedge clk);
    check("held_digits", digits, 32'h01234);
    check("idle_after_ignore", busy, 0);

    // Reset in the 8th CONVERT cycle aborts without done.
    run(16'd42, off, bc);
    check("prev_result_42", digits, 32'h00042);
    start = 1'b1;
    bin   = 16'd54321;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_outputs", {9'd0, busy, done, z_axis_sign, digits}, 32'd0);
    dcnt = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check("abort_no_done", dcnt, 0);

    // Reset wins over start on the same edge.
    reset = 1'b1;
    start = 1'b1;
    bin   = 16'd7;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    check("reset_beats_start", busy, 0);

    // Most negative value / 32768.
    run(16'h8000, off, bc);
`ifdef Z_AXIS_SIGNED_EN
    check("h8000_result", {z_axis_sign, digits}, {1'b1, 20'h32768});
`else
    check("h8000_result", {z_axis_sign, digits}, {1'b0, 20'h32768});
`endif

    // Start held high: one conversion every 18 cycles.
    start  = 1'b1;
    bin    = 16'h8000;
    idx    = 0;
    first  = -1;
    second = -1;
    repeat (60) begin
      @(negedge clk);
      idx++;
      if (done) begin
        if (first < 0) first = idx;
        else if (second < 0) second = idx;
      end
    end
    start = 1'b0;
    check("held_start_period", second - first, 18);
    repeat (20) @(negedge clk);

    // Random traffic against the model.
    repeat (600) begin
      @(negedge clk);
      reset = ($urandom_range(0, 63) == 0);
      start = ($urandom_range(0, 3) == 0);
      bin   = 16'($urandom);
    end
    reset = 1'b0;
    start = 1'b0;
    repeat (20) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
